// File: rtl/pbox_context_sequencer.sv
// Context store and run sequencer feeding one PBox predication unit.
// Replays a contiguous, wrapping run of stored context words, one per enabled cycle.
module pbox_context_sequencer #(
    parameter int unsigned CTX_WIDTH = 16,
    parameter int unsigned CTX_DEPTH = 64,
    parameter int unsigned ADDR_W    = 6,
    parameter int unsigned LEN_W     = 7
) (
    input  logic                 CLK_I,
    input  logic                 RST_N_I,
    input  logic                 CFG_WR_EN_I,
    input  logic [ADDR_W-1:0]    CFG_WR_ADDR_I,
    input  logic [CTX_WIDTH-1:0] CFG_WR_DATA_I,
    input  logic                 START_I,
    input  logic [ADDR_W-1:0]    START_ADDR_I,
    input  logic [LEN_W-1:0]     LENGTH_I,
    input  logic                 STALL_I,
    output logic [CTX_WIDTH-1:0] CONTEXT_O,
    output logic                 PBOX_EN_O,
    output logic                 BUSY_O,
    output logic                 DONE_O,
    output logic                 CFG_ERR_O
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    logic [CTX_WIDTH-1:0] r_mem [CTX_DEPTH];
    logic [ADDR_W-1:0]    r_pc;
    logic [LEN_W-1:0]     r_rem;
    logic [CTX_WIDTH-1:0] r_context;
    logic                 r_pbox_en;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_cfg_err;

    logic                 w_wr_ok;
    logic [CTX_WIDTH-1:0] w_start_word;

    assign w_wr_ok = CFG_WR_EN_I && (r_state == S_IDLE);

    // A write to the start slot in the START cycle is forwarded so the run sees the new word.
    assign w_start_word = (w_wr_ok && (CFG_WR_ADDR_I == START_ADDR_I)) ? CFG_WR_DATA_I
                                                                       : r_mem[START_ADDR_I];

    // Context memory survives reset; it is only written while idle.
    always_ff @(posedge CLK_I) begin
        if (w_wr_ok) begin
            r_mem[CFG_WR_ADDR_I] <= CFG_WR_DATA_I;
        end
    end

    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_state   <= S_IDLE;
            r_pc      <= '0;
            r_rem     <= '0;
            r_context <= '0;
            r_pbox_en <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cfg_err <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_cfg_err <= CFG_WR_EN_I && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (START_I) begin
                        r_busy <= 1'b1;
                        if (LENGTH_I != '0) begin
                            r_context <= w_start_word;
                            r_pbox_en <= 1'b1;
                            r_pc      <= START_ADDR_I + 1'b1;
                            r_rem     <= LENGTH_I - 1'b1;
                            r_state   <= S_RUN;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RUN: begin
                    // The word on the bus was consumed on its enabled cycle; a stall only holds it.
                    if (STALL_I) begin
                        r_pbox_en <= 1'b0;
                    end else if (r_rem != '0) begin
                        r_context <= r_mem[r_pc];
                        r_pc      <= r_pc + 1'b1;
                        r_rem     <= r_rem - 1'b1;
                        r_pbox_en <= 1'b1;
                    end else begin
                        r_context <= '0;
                        r_pbox_en <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy    <= 1'b0;
                    r_pbox_en <= 1'b0;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

    assign CONTEXT_O = r_context;
    assign PBOX_EN_O = r_pbox_en;
    assign BUSY_O    = r_busy;
    assign DONE_O    = r_done;
    assign CFG_ERR_O = r_cfg_err;

endmodule
